// File: rtl/bank_read_streamer.sv
// rtl/bank_read_streamer.sv - burst reader from a memory bank into a 4-deep skid FIFO stream
// Reads issue only while the FIFO plus in-flight reads can absorb them, so backpressure never overflows.
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif
`ifndef WID_RAM
`define WID_RAM 16
`endif

module bank_read_streamer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [`ADDR_RAM-1:0] base_addr,
   input  logic [`ADDR_RAM:0]   length,
   output logic                 mem_re,
   output logic [`ADDR_RAM-1:0] mem_rd_addr,
   input  logic [`WID_RAM-1:0]  mem_data_out,
   output logic                 m_valid,
   output logic [`WID_RAM-1:0]  m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);
   localparam int AW = `ADDR_RAM;
   localparam int WW = `WID_RAM;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   issue_cnt;
   logic [AW:0]   deliver_cnt;
   logic          re_d;
   logic [WW-1:0] fifo_mem [0:3];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fifo_count;
   logic [2:0]    occupancy;
   logic          accept, push, pop;

   // re_d is the single read in flight (memory latency is one cycle)
   assign occupancy   = fifo_count + {2'b00, re_d};
   assign mem_re      = (state == RUN) && (issue_cnt != '0) && (occupancy < 3'(FIFO_DEPTH));
   assign mem_rd_addr = rd_addr;
   assign push        = re_d;
   assign m_valid     = (fifo_count != 3'd0);
   assign pop         = m_valid && m_ready;
   assign m_data      = m_valid ? fifo_mem[rd_ptr] : '0;
   assign m_last      = m_valid && (deliver_cnt == (AW+1)'(1));
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = (length != '0) ? RUN : DONE;
            end
         end
         RUN:     if (pop && m_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_addr     <= '0;
         issue_cnt   <= '0;
         deliver_cnt <= '0;
         re_d        <= 1'b0;
      end else begin
         state <= state_nx;
         re_d  <= mem_re;
         if (accept) begin
            rd_addr   <= base_addr;
            issue_cnt <= length;
         end else if (mem_re) begin
            rd_addr   <= rd_addr + AW'(1);
            issue_cnt <= issue_cnt - (AW+1)'(1);
         end
         if (accept)
            deliver_cnt <= length;
         else if (pop)
            deliver_cnt <= deliver_cnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset; m_data is gated by m_valid
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_data_out;
   end

endmodule
